inst_fetch_unit: RTL and testbench
==================================

# inst_fetch_unit

Parametrised instruction fetch stage with an integrated byte-serial program loader. The loader assembles 8-bit loader bytes into 32-bit words and writes them into an internal instruction RAM. The fetch port reads that RAM with one-cycle latency, honours a pipeline stall, and forwards the aligned `pc`/`pc1` pair. It sits between the host program-loader link and the decode stage, and gates core execution through `inst_enable`.

## Interface
- `ADDR_WIDTH`, 10, word-address width; RAM depth = 2**ADDR_WIDTH words.
- `BIG_ENDIAN`, 1, 1: the first loader byte of a word lands in bits [31:24]; 0: it lands in bits [7:0].

- `CLK`  in  1  clock, all state on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `input_data`  in  8  loader byte.
- `input_start`  in  1  begin or restart a program load.
- `input_end`  in  1  end of program load.
- `input_valid`  in  1  `input_data` valid.
- `input_ready`  out  1  loader accepts a byte this cycle.
- `pc`  in  ADDR_WIDTH  fetch word address.
- `pc1`  in  ADDR_WIDTH  companion address (pc+1), passed through.
- `fetch_req`  in  1  request a fetch at `pc`.
- `stall`  in  1  downstream stall; hold all fetch outputs.
- `inst`  out  32  fetched instruction.
- `inst_valid`  out  1  `inst`/`pc_next`/`pc1_next` valid.
- `inst_enable`  out  1  core run enable.
- `pc_next`  out  ADDR_WIDTH  address of `inst`.
- `pc1_next`  out  ADDR_WIDTH  `pc1` captured with `inst`.
- `load_words`  out  ADDR_WIDTH+1  complete or padded words written by the last load.
- `load_error`  out  1  last load overflowed or ended on a partial word.

## Operation
- FSM states are RUN, LOAD and FINISH. Reset state is RUN.
- **RUN**
  - `inst_enable`=1, `input_ready`=0.
  - On `input_start`: go to LOAD, clear `inst_valid`, `load_words`, `load_error`, the byte counter and the write address.
- **LOAD**
  - `inst_enable`=0, `input_ready`=1, no fetches issued.
  - Each accepted byte (`input_valid` && `input_ready`) enters the assembly register at the slot given by the 2-bit byte counter and `BIG_ENDIAN`.
  - On the 4th byte, the word is written to the write address; the write address and `load_words` increment and the byte counter wraps to 0.
  - When `load_words` == 2**ADDR_WIDTH, further words are discarded and `load_error` is set.
  - `input_start` in LOAD restarts the load: all counters and `load_error` are cleared and the RAM is not cleared.
  - `input_end`: go to FINISH. If the byte counter != 0, the partial word is zero-padded and written, `load_words` increments, and `load_error` is set.
  - If `input_valid` and `input_end` are asserted together, the byte is accepted first, then end is processed.
  - If `input_start` and `input_end` are asserted together, start wins.
- **FINISH**: lasts exactly one cycle, then RUN. `inst_enable` is 0 during FINISH.
- **Fetch (RUN only)**
  - `fetch_req` && !`stall` issues a synchronous read at `pc` and captures `pc`/`pc1`.
  - !`fetch_req` && !`stall` clears `inst_valid` on the next edge.
  - `stall`=1: no read is issued, and `inst`, `inst_valid`, `pc_next` and `pc1_next` hold.
- RAM contents survive reset; only registers are reset.

## Timing
- Reset values: `inst`=0, `inst_valid`=0, `inst_enable`=1, `input_ready`=0, `pc_next`=0, `pc1_next`=0, `load_words`=0, `load_error`=0, FSM=RUN.
- Fetch latency is 1: a request at edge k gives `inst`/`inst_valid`/`pc_next` after edge k.
- A byte stream is accepted at full rate, one byte per cycle.
- Write timing: the word is written at the edge that accepts its 4th byte, and is readable by any fetch issued in RUN.
- `input_end` at edge k: FINISH after k, RUN and `inst_enable`=1 after k+1.
- `reset_n` asserted mid-load: immediate return to reset values; the partial word is lost.

## Structure
- Package `fetch_pkg` holds:
  - state enum `fetch_state_t` (RUN, LOAD, FINISH);
  - `INST_WIDTH`=32, `BYTE_WIDTH`=8, `BYTES_PER_WORD`=4.
- Sub-module `inst_ram`: simple dual-port, one write port and one synchronous read port, parametrised by `ADDR_WIDTH`, no reset on the array.

## Test plan
- **Little-endian load.** `BIG_ENDIAN`=0; start, bytes 0x11,0x22,0x33,0x44,0x55,0x66,0x77,0x88, end; then fetch pc=1, pc1=2.
  - After end: `load_words`=2, `load_error`=0.
  - One cycle after the fetch: `inst`=0x88776655, `pc_next`=1, `pc1_next`=2.
- **Big-endian load with partial word.** `BIG_ENDIAN`=1; bytes 0xDE,0xAD,0xBE,0xEF,0x01, end.
  - Word 0 = 0xDEADBEEF, word 1 = 0x01000000.
  - `load_words`=2, `load_error`=1.
- **Overflow.** `ADDR_WIDTH`=2; load 20 bytes.
  - `load_words`=4, `load_error`=1.
  - Word 0 holds the first 4 bytes, not bytes 17–20.
- **Stall.** Fetch at pc=3 with `stall` asserted for 3 cycles while `pc` changes to 7.
  - `inst`, `pc_next`=3 and `inst_valid`=1 hold throughout the stall.
  - Release: pc 7 data appears one cycle later.
- **Restart and simultaneous events.**
  - `input_start` mid-word: counters clear and `load_words`=0.
  - `input_start`+`input_end` together: the block stays in LOAD.
  - `input_valid`+`input_end` together on the 4th byte: the word is written, `load_error`=0.
- **Async reset mid-load.** Deassert `reset_n` after 2 bytes.
  - All outputs take their reset values immediately and `inst_enable`=1.
  - Previously loaded words are still fetchable.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage and its program loader.
package fetch_pkg;

  localparam int unsigned INST_WIDTH     = 32;
  localparam int unsigned BYTE_WIDTH     = 8;
  localparam int unsigned BYTES_PER_WORD = 4;

  typedef enum logic [1:0] {
    RUN,
    LOAD,
    FINISH
  } fetch_state_t;

  // Bit offset of loader byte `slot` inside the assembled word.
  function automatic logic [4:0] byte_shift(input logic [1:0] slot, input logic big_endian);
    return big_endian ? {~slot, 3'b000} : {slot, 3'b000};
  endfunction

endpackage

// File: rtl/inst_ram.sv
// Instruction RAM: one write port, one registered read port. The array itself is never reset,
// so a loaded program survives reset; only the read-data register is cleared.
module inst_ram
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  CLK,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [INST_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [INST_WIDTH-1:0] rd_data
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [INST_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read data holds when no read is issued; this is what keeps `inst` stable under stall.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage with a byte-serial program loader that assembles 32-bit words
// into the instruction RAM and gates core execution while a load is in progress.
module inst_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter bit          BIG_ENDIAN = 1'b1
) (
  input  logic                  CLK,
  input  logic                  reset_n,
  input  logic [BYTE_WIDTH-1:0] input_data,
  input  logic                  input_start,
  input  logic                  input_end,
  input  logic                  input_valid,
  output logic                  input_ready,
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic [ADDR_WIDTH-1:0] pc1,
  input  logic                  fetch_req,
  input  logic                  stall,
  output logic [INST_WIDTH-1:0] inst,
  output logic                  inst_valid,
  output logic                  inst_enable,
  output logic [ADDR_WIDTH-1:0] pc_next,
  output logic [ADDR_WIDTH-1:0] pc1_next,
  output logic [ADDR_WIDTH:0]   load_words,
  output logic                  load_error
);

  localparam int unsigned LW_WIDTH = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] FULL_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};

  fetch_state_t          state_q, state_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_WIDTH:0]   load_words_q, load_words_d;
  logic                  load_error_q, load_error_d;
  logic [INST_WIDTH-1:0] asm_q, asm_d;
  logic                  inst_valid_q, inst_valid_d;
  logic [ADDR_WIDTH-1:0] pc_next_q, pc_next_d;
  logic [ADDR_WIDTH-1:0] pc1_next_q, pc1_next_d;

  logic                  ram_we, ram_re;
  logic [INST_WIDTH-1:0] ram_wdata, ram_rdata;
  logic [INST_WIDTH-1:0] word_v;
  logic [1:0]            cnt_v;
  logic                  commit;

  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    wr_addr_d    = wr_addr_q;
    load_words_d = load_words_q;
    load_error_d = load_error_q;
    asm_d        = asm_q;
    inst_valid_d = inst_valid_q;
    pc_next_d    = pc_next_q;
    pc1_next_d   = pc1_next_q;
    ram_we       = 1'b0;
    ram_re       = 1'b0;
    ram_wdata    = '0;
    word_v       = asm_q;
    cnt_v        = byte_cnt_q;
    commit       = 1'b0;
    input_ready  = 1'b0;
    inst_enable  = 1'b0;

    unique case (state_q)
      RUN: begin
        inst_enable = 1'b1;
        if (input_start) begin
          state_d      = LOAD;
          inst_valid_d = 1'b0;
          byte_cnt_d   = '0;
          wr_addr_d    = '0;
          load_words_d = '0;
          load_error_d = 1'b0;
          asm_d        = '0;
        end else if (!stall) begin
          ram_re       = fetch_req;
          inst_valid_d = fetch_req;
          if (fetch_req) begin
            pc_next_d  = pc;
            pc1_next_d = pc1;
          end
        end
      end

      LOAD: begin
        input_ready = 1'b1;
        if (input_start) begin
          // Restart: RAM keeps whatever was written so far.
          byte_cnt_d   = '0;
          wr_addr_d    = '0;
          load_words_d = '0;
          load_error_d = 1'b0;
          asm_d        = '0;
        end else begin
          if (input_valid) begin
            word_v = asm_q | (INST_WIDTH'(input_data) << byte_shift(byte_cnt_q, BIG_ENDIAN));
            cnt_v  = byte_cnt_q + 2'd1;
          end
          // A full word and a padded partial flush are mutually exclusive in one cycle.
          commit     = (input_valid && (byte_cnt_q == 2'd3)) || (input_end && (cnt_v != 2'd0));
          asm_d      = word_v;
          byte_cnt_d = cnt_v;
          if (commit) begin
            asm_d      = '0;
            byte_cnt_d = '0;
            if (load_words_q == FULL_COUNT) begin
              load_error_d = 1'b1;
            end else begin
              ram_we       = 1'b1;
              ram_wdata    = word_v;
              wr_addr_d    = wr_addr_q + ADDR_WIDTH'(1);
              load_words_d = load_words_q + LW_WIDTH'(1);
            end
          end
          if (input_end) begin
            state_d = FINISH;
            if (cnt_v != 2'd0) begin
              load_error_d = 1'b1;
            end
          end
        end
      end

      FINISH: begin
        state_d = RUN;
      end

      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= RUN;
      byte_cnt_q   <= '0;
      wr_addr_q    <= '0;
      load_words_q <= '0;
      load_error_q <= 1'b0;
      asm_q        <= '0;
      inst_valid_q <= 1'b0;
      pc_next_q    <= '0;
      pc1_next_q   <= '0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      wr_addr_q    <= wr_addr_d;
      load_words_q <= load_words_d;
      load_error_q <= load_error_d;
      asm_q        <= asm_d;
      inst_valid_q <= inst_valid_d;
      pc_next_q    <= pc_next_d;
      pc1_next_q   <= pc1_next_d;
    end
  end

  inst_ram #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_inst_ram (
    .CLK     (CLK),
    .reset_n (reset_n),
    .wr_en   (ram_we),
    .wr_addr (wr_addr_q),
    .wr_data (ram_wdata),
    .rd_en   (ram_re),
    .rd_addr (pc),
    .rd_data (ram_rdata)
  );

  assign inst       = ram_rdata;
  assign inst_valid = inst_valid_q;
  assign pc_next    = pc_next_q;
  assign pc1_next   = pc1_next_q;
  assign load_words = load_words_q;
  assign load_error = load_error_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench: two fetch units (little-endian 16 words, big-endian 4 words) share one loader stream
// and are checked against a word-array model of what each load should leave in RAM.
module tb_inst_fetch_unit;

  localparam int AW_A    = 4;
  localparam int AW_B    = 2;
  localparam int DEPTH_A = 16;
  localparam int DEPTH_B = 4;

  logic            CLK = 1'b0;
  logic            reset_n = 1'b0;
  logic [7:0]      input_data = '0;
  logic            input_start = 1'b0;
  logic            input_end = 1'b0;
  logic            input_valid = 1'b0;
  logic            fetch_req = 1'b0;
  logic            stall = 1'b0;
  logic [AW_A-1:0] pc_a = '0, pc1_a = '0;
  logic [AW_B-1:0] pc_b = '0, pc1_b = '0;

  logic            input_ready_a, inst_valid_a, inst_enable_a, load_error_a;
  logic [31:0]     inst_a;
  logic [AW_A-1:0] pc_next_a, pc1_next_a;
  logic [AW_A:0]   load_words_a;
  logic            input_ready_b, inst_valid_b, inst_enable_b, load_error_b;
  logic [31:0]     inst_b;
  logic [AW_B-1:0] pc_next_b, pc1_next_b;
  logic [AW_B:0]   load_words_b;

  inst_fetch_unit #(.ADDR_WIDTH(AW_A), .BIG_ENDIAN(1'b0)) dut_a (
    .CLK(CLK), .reset_n(reset_n), .input_data(input_data), .input_start(input_start),
    .input_end(input_end), .input_valid(input_valid), .input_ready(input_ready_a),
    .pc(pc_a), .pc1(pc1_a), .fetch_req(fetch_req), .stall(stall), .inst(inst_a),
    .inst_valid(inst_valid_a), .inst_enable(inst_enable_a), .pc_next(pc_next_a),
    .pc1_next(pc1_next_a), .load_words(load_words_a), .load_error(load_error_a)
  );

  inst_fetch_unit #(.ADDR_WIDTH(AW_B), .BIG_ENDIAN(1'b1)) dut_b (
    .CLK(CLK), .reset_n(reset_n), .input_data(input_data), .input_start(input_start),
    .input_end(input_end), .input_valid(input_valid), .input_ready(input_ready_b),
    .pc(pc_b), .pc1(pc1_b), .fetch_req(fetch_req), .stall(stall), .inst(inst_b),
    .inst_valid(inst_valid_b), .inst_enable(inst_enable_b), .pc_next(pc_next_b),
    .pc1_next(pc1_next_b), .load_words(load_words_b), .load_error(load_error_b)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  logic [31:0]     mem_a [DEPTH_A];
  logic [31:0]     mem_b [DEPTH_B];
  logic [31:0]     exp_inst_a = '0, exp_inst_b = '0;
  logic            exp_valid = 1'b0;
  logic [AW_A-1:0] exp_pc_a = '0, exp_pc1_a = '0;
  logic [AW_B-1:0] exp_pc_b = '0, exp_pc1_b = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [31:0] pack(input logic [7:0] q[$], input int base, input bit be);
    logic [31:0] w = '0;
    for (int j = 0; j < 4; j++) begin
      logic [31:0] b = (base + j < q.size()) ? {24'd0, q[base+j]} : 32'd0;
      w |= be ? (b << (8 * (3 - j))) : (b << (8 * j));
    end
    return w;
  endfunction

  task automatic model_reset();
    exp_inst_a = '0; exp_inst_b = '0; exp_valid = 1'b0;
    exp_pc_a = '0; exp_pc1_a = '0; exp_pc_b = '0; exp_pc1_b = '0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    input_valid = 1'b1;
    input_data  = b;
    tick();
    input_valid = 1'b0;
  endtask

  // Full load from RUN: start, bytes with random idle gaps, end (optionally with the last byte).
  task automatic do_load(input logic [7:0] q[$], input bit end_with_last, input int max_gap);
    int nw, wa, wb;
    bit part;
    input_start = 1'b1;
    tick();
    input_start = 1'b0;
    exp_valid = 1'b0;
    chk("load_ready_a", input_ready_a, 1);
    chk("load_enable_b", inst_enable_b, 0);
    for (int i = 0; i < q.size(); i++) begin
      repeat ($urandom_range(max_gap, 0)) tick();
      input_valid = 1'b1;
      input_data  = q[i];
      if (end_with_last && (i == q.size() - 1)) input_end = 1'b1;
      tick();
      input_valid = 1'b0;
      input_end   = 1'b0;
    end
    if (!end_with_last || (q.size() == 0)) begin
      input_end = 1'b1;
      tick();
      input_end = 1'b0;
    end
    nw   = (q.size() + 3) / 4;
    part = (q.size() % 4) != 0;
    for (int i = 0; i < nw; i++) begin
      if (i < DEPTH_A) mem_a[i] = pack(q, 4 * i, 1'b0);
      if (i < DEPTH_B) mem_b[i] = pack(q, 4 * i, 1'b1);
    end
    wa = (nw < DEPTH_A) ? nw : DEPTH_A;
    wb = (nw < DEPTH_B) ? nw : DEPTH_B;
    chk("finish_enable_a", inst_enable_a, 0);
    chk("finish_enable_b", inst_enable_b, 0);
    chk("load_words_a", load_words_a, wa);
    chk("load_error_a", load_error_a, part || (nw > DEPTH_A));
    chk("load_words_b", load_words_b, wb);
    chk("load_error_b", load_error_b, part || (nw > DEPTH_B));
    tick();
    chk("run_enable_a", inst_enable_a, 1);
    chk("run_enable_b", inst_enable_b, 1);
    chk("run_ready_a", input_ready_a, 0);
  endtask

  task automatic fstep(input bit req, input bit stl, input logic [AW_A-1:0] pa,
                       input logic [AW_B-1:0] pb);
    fetch_req = req;
    stall     = stl;
    pc_a  = pa;
    pc1_a = pa + AW_A'(1);
    pc_b  = pb;
    pc1_b = pb + AW_B'(1);
    if (!stl) begin
      exp_valid = req;
      if (req) begin
        exp_inst_a = mem_a[pa]; exp_pc_a = pa; exp_pc1_a = pa + AW_A'(1);
        exp_inst_b = mem_b[pb]; exp_pc_b = pb; exp_pc1_b = pb + AW_B'(1);
      end
    end
    tick();
    chk("inst_a", inst_a, exp_inst_a);
    chk("inst_valid_a", inst_valid_a, exp_valid);
    chk("pc_next_a", pc_next_a, exp_pc_a);
    chk("pc1_next_a", pc1_next_a, exp_pc1_a);
    chk("inst_b", inst_b, exp_inst_b);
    chk("inst_valid_b", inst_valid_b, exp_valid);
    chk("pc_next_b", pc_next_b, exp_pc_b);
    chk("pc1_next_b", pc1_next_b, exp_pc1_b);
    fetch_req = 1'b0;
    stall     = 1'b0;
  endtask

  task automatic random_fetches(input int n);
    for (int i = 0; i < n; i++) begin
      fstep(1'($urandom_range(1, 0)), ($urandom_range(3, 0) == 0),
            AW_A'($urandom_range(DEPTH_A - 1, 0)), AW_B'($urandom_range(DEPTH_B - 1, 0)));
    end
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] q2[$];

    // Reset values
    repeat (2) tick();
    chk("rst_inst_a", inst_a, 0);
    chk("rst_valid_a", inst_valid_a, 0);
    chk("rst_enable_a", inst_enable_a, 1);
    chk("rst_ready_a", input_ready_a, 0);
    chk("rst_pc_next_a", pc_next_a, 0);
    chk("rst_words_b", load_words_b, 0);
    chk("rst_error_b", load_error_b, 0);
    reset_n = 1'b1;
    tick();

    // Fill every word of both RAMs (the 4-word unit overflows)
    q = {};
    for (int i = 0; i < 64; i++) q.push_back(8'($urandom));
    do_load(q, 1'b0, 1);
    random_fetches(20);

    // Little-endian load
    q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    do_load(q, 1'b0, 0);
    fstep(1'b1, 1'b0, 4'd1, 2'd1);
    chk("le_word1", inst_a, 32'h88776655);
    chk("le_pc_next", pc_next_a, 1);
    chk("le_pc1_next", pc1_next_a, 2);
    chk("le_words", load_words_a, 2);

    // Big-endian load ending on a partial word
    q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01};
    do_load(q, 1'b0, 0);
    chk("be_error", load_error_b, 1);
    fstep(1'b1, 1'b0, 4'd0, 2'd0);
    chk("be_word0", inst_b, 32'hDEADBEEF);
    fstep(1'b1, 1'b0, 4'd1, 2'd1);
    chk("be_word1", inst_b, 32'h01000000);

    // Overflow of the 4-word unit
    q = {};
    for (int i = 1; i <= 20; i++) q.push_back(8'(i));
    do_load(q, 1'b0, 0);
    chk("ovf_words", load_words_b, 4);
    chk("ovf_error", load_error_b, 1);
    fstep(1'b1, 1'b0, 4'd0, 2'd0);
    chk("ovf_word0", inst_b, 32'h01020304);

    // Stall holds all fetch outputs
    fstep(1'b1, 1'b0, 4'd3, 2'd3);
    for (int i = 0; i < 3; i++) begin
      fstep(1'b1, 1'b1, 4'd7, 2'd1);
      chk("stall_pc_next", pc_next_a, 3);
      chk("stall_valid", inst_valid_a, 1);
    end
    fstep(1'b1, 1'b0, 4'd7, 2'd1);
    chk("release_pc_next", pc_next_a, 7);
    fstep(1'b0, 1'b0, 4'd2, 2'd2);
    chk("idle_clears_valid", inst_valid_a, 0);

    // Restart mid-word, start+end together, valid+end on the 4th byte
    input_start = 1'b1;
    tick();
    input_start = 1'b0;
    exp_valid = 1'b0;
    send_byte(8'hAA);
    send_byte(8'hBB);
    input_start = 1'b1;
    tick();
    input_start = 1'b0;
    chk("restart_words", load_words_a, 0);
    chk("restart_ready", input_ready_a, 1);
    q = '{8'h01, 8'h02, 8'h03, 8'h04};
    for (int i = 0; i < 3; i++) send_byte(q[i]);
    chk("restart_cnt_cleared", load_words_a, 0);
    send_byte(q[3]);
    chk("restart_word_done", load_words_a, 1);
    input_start = 1'b1;
    input_end   = 1'b1;
    tick();
    input_start = 1'b0;
    input_end   = 1'b0;
    chk("start_end_ready", input_ready_a, 1);
    chk("start_end_enable", inst_enable_a, 0);
    chk("start_end_words", load_words_a, 0);
    q2 = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
    for (int i = 0; i < 3; i++) send_byte(q2[i]);
    input_valid = 1'b1;
    input_end   = 1'b1;
    input_data  = q2[3];
    tick();
    input_valid = 1'b0;
    input_end   = 1'b0;
    chk("valid_end_finish", inst_enable_a, 0);
    chk("valid_end_words", load_words_a, 1);
    chk("valid_end_error", load_error_a, 0);
    tick();
    chk("valid_end_run", inst_enable_a, 1);
    mem_a[0] = pack(q2, 0, 1'b0);
    mem_b[0] = pack(q2, 0, 1'b1);
    fstep(1'b1, 1'b0, 4'd0, 2'd0);
    chk("valid_end_word0", inst_a, 32'hC4C3C2C1);

    // Randomized loads followed by randomized fetch traffic
    for (int it = 0; it < 6; it++) begin
      q = {};
      for (int i = 0; i < $urandom_range(24, 1); i++) q.push_back(8'($urandom));
      do_load(q, 1'($urandom_range(1, 0)), 2);
      random_fetches(25);
    end

    // Asynchronous reset mid-load: first word already written, partial word lost
    fstep(1'b1, 1'b0, 4'd5, 2'd2);
    q = {};
    for (int i = 0; i < 6; i++) q.push_back(8'($urandom));
    input_start = 1'b1;
    tick();
    input_start = 1'b0;
    for (int i = 0; i < 6; i++) send_byte(q[i]);
    chk("pre_reset_words", load_words_a, 1);
    mem_a[0] = pack(q, 0, 1'b0);
    mem_b[0] = pack(q, 0, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_inst_a", inst_a, 0);
    chk("arst_inst_b", inst_b, 0);
    chk("arst_valid_a", inst_valid_a, 0);
    chk("arst_enable_a", inst_enable_a, 1);
    chk("arst_enable_b", inst_enable_b, 1);
    chk("arst_ready_a", input_ready_a, 0);
    chk("arst_pc_next_a", pc_next_a, 0);
    chk("arst_pc1_next_a", pc1_next_a, 0);
    chk("arst_words_a", load_words_a, 0);
    chk("arst_error_b", load_error_b, 0);
    tick();
    reset_n = 1'b1;
    model_reset();
    tick();
    fstep(1'b1, 1'b0, 4'd0, 2'd0);
    fstep(1'b1, 1'b0, 4'd1, 2'd1);
    random_fetches(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
